// File: rtl/dft_pkg.sv
// Shared definitions for the 64-point DFT sample loader.
// Holds frame geometry constants, the sample type and the drain FSM state
// encoding used by dft64_sample_loader and dft_sample_bank.
package dft_pkg;

  localparam int SAMPLE_W = 16;
  localparam int N_POINTS = 64;
  localparam int LANES    = 8;
  localparam int ROWS     = N_POINTS / LANES;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/dft_sample_bank.sv
// One frame of sample storage: N_POINTS x SAMPLE_W registers.
// Ports:
//   clk      - write clock
//   we       - write enable for this bank
//   addr     - write address (sample index within the frame)
//   data     - sample to write
//   row      - column-read row select
//   samples  - LANES samples of the selected row, lane m = mem[ROWS*m + row]
// Storage carries no reset: stale contents are never presented because the
// loader only drains a bank whose full flag has been set by a complete fill.
module dft_sample_bank #(
  parameter int SAMPLE_W = dft_pkg::SAMPLE_W,
  parameter int N_POINTS = dft_pkg::N_POINTS,
  parameter int LANES    = dft_pkg::LANES
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [$clog2(N_POINTS)-1:0]           addr,
  input  logic [SAMPLE_W-1:0]                   data,
  input  logic [$clog2(N_POINTS/LANES)-1:0]     row,
  output logic [SAMPLE_W-1:0]                   samples [0:LANES-1]
);
  import dft_pkg::*;

  localparam int N_ROWS = N_POINTS / LANES;
  localparam int ADDR_W = $clog2(N_POINTS);

  logic [SAMPLE_W-1:0] mem [0:N_POINTS-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
  end

  // Stride-N_ROWS column read: lane m picks x[N_ROWS*m + row].
  for (genvar m = 0; m < LANES; m++) begin : g_lane
    assign samples[m] = mem[ADDR_W'(m * N_ROWS) + ADDR_W'(row)];
  end

endmodule

// File: rtl/dft64_sample_loader.sv
// Upstream feeder for the 64-point DFT stage.
// Collects serial samples into a ping-pong pair of banks and drains each
// full frame as N_POINTS/LANES rows of LANES samples in stride order,
// then waits for the DFT's done pulse before draining the next frame.
// Ports:
//   clk, sreset_n  - clock, asynchronous active-low reset
//   in_data/in_valid/in_ready - serial sample input handshake
//   dft_done       - frame-processed pulse from the DFT stage
//   samples        - current row (registered)
//   rel            - row valid, high for one frame's worth of rows
//   calculate      - DFT accumulate enable, DRAIN through WAIT_DONE
//   frame_start    - pulse alongside row 0
module dft64_sample_loader #(
  parameter int SAMPLE_W = dft_pkg::SAMPLE_W,
  parameter int N_POINTS = dft_pkg::N_POINTS,
  parameter int LANES    = dft_pkg::LANES
) (
  input  logic                clk,
  input  logic                sreset_n,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                dft_done,
  output logic [SAMPLE_W-1:0] samples [0:LANES-1],
  output logic                rel,
  output logic                calculate,
  output logic                frame_start
);
  import dft_pkg::*;

  localparam int N_ROWS = N_POINTS / LANES;
  localparam int ADDR_W = $clog2(N_POINTS);
  localparam int ROW_W  = $clog2(N_ROWS);

  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [ROW_W-1:0]    row;
  logic                active;
  logic                wr_fire;
  logic                load;
  logic                drain_last;
  loader_state_t       state;
  loader_state_t       state_next;
  logic [SAMPLE_W-1:0] col0 [0:LANES-1];
  logic [SAMPLE_W-1:0] col1 [0:LANES-1];

  // active holds in_ready low until the first edge after reset release.
  assign in_ready = active && !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;

  dft_sample_bank #(.SAMPLE_W(SAMPLE_W), .N_POINTS(N_POINTS), .LANES(LANES)) u_bank0 (
    .clk     (clk),
    .we      (wr_fire && !wr_bank),
    .addr    (wr_cnt),
    .data    (in_data),
    .row     (row),
    .samples (col0)
  );

  dft_sample_bank #(.SAMPLE_W(SAMPLE_W), .N_POINTS(N_POINTS), .LANES(LANES)) u_bank1 (
    .clk     (clk),
    .we      (wr_fire && wr_bank),
    .addr    (wr_cnt),
    .data    (in_data),
    .row     (row),
    .samples (col1)
  );

  always_ff @(posedge clk or negedge sreset_n) begin
    if (!sreset_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (full[rd_bank])               state_next = DRAIN;
      DRAIN:     if (row == ROW_W'(N_ROWS - 1))   state_next = WAIT_DONE;
      WAIT_DONE: if (dft_done)                    state_next = IDLE;
      default:                                    state_next = IDLE;
    endcase
  end

  // Row 0 is loaded on the IDLE->DRAIN edge so it is visible in the first
  // DRAIN cycle; the last row is loaded on the DRAIN->WAIT_DONE edge.
  always_comb begin
    load       = ((state == IDLE) && full[rd_bank]) || (state == DRAIN);
    drain_last = (state == DRAIN) && (row == ROW_W'(N_ROWS - 1));
    calculate  = (state == DRAIN) || (state == WAIT_DONE);
  end

  // Set and clear of full never target the same bank: a bank being written
  // is empty, a bank being drained is full.
  always_ff @(posedge clk or negedge sreset_n) begin
    if (!sreset_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      row     <= '0;
      active  <= 1'b0;
    end else begin
      active <= 1'b1;
      if (wr_fire) begin
        if (wr_cnt == ADDR_W'(N_POINTS - 1)) begin
          wr_cnt        <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (load) row <= drain_last ? '0 : row + 1'b1;
      if (drain_last) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // Output row register; samples hold their last row through WAIT_DONE.
  always_ff @(posedge clk or negedge sreset_n) begin
    if (!sreset_n) begin
      rel         <= 1'b0;
      frame_start <= 1'b0;
      for (int m = 0; m < LANES; m++) samples[m] <= '0;
    end else begin
      rel         <= load;
      frame_start <= load && (state == IDLE);
      if (load) begin
        for (int m = 0; m < LANES; m++) samples[m] <= rd_bank ? col1[m] : col0[m];
      end
    end
  end

endmodule
